ysyx_22040125_stage_reg: RTL
============================

# ysyx_22040125_stage_reg

Generic, parametrised pipeline stage register replacing the fixed-field inter-stage registers (IF/ID, ID/EXE, EXE/MEM, MEM/WB) of the ysyx_22040125 RV64 core. Carries an opaque WIDTH-bit payload with a valid/ready handshake, synchronous flush, and a saturating back-pressure counter. An optional skid entry provides full throughput with a registered `in_ready`. One instance sits between each pair of adjacent pipeline stages; each instance's payload is the packed field bundle defined for that boundary.

## Interface
- WIDTH, 64: payload width in bits (≥1)
- CNT_W, 32: stall counter width in bits (≥1)

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  kill all held beats this cycle (branch mispredict / trap redirect)
- in_valid  in  1  upstream beat present
- in_ready  out  1  stage can accept a beat
- in_data  in  WIDTH  upstream payload
- out_valid  out  1  beat presented downstream
- out_ready  in  1  downstream accepts
- out_data  out  WIDTH  payload presented downstream
- occupancy  out  2  beats held (0, 1, 2; 2 only with skid)
- stall_cnt  out  CNT_W  cycles with out_valid && !out_ready, saturating

## Operation
- Handshakes: an input beat transfers when in_valid && in_ready. An output beat transfers when out_valid && out_ready. in_data is sampled only on an input transfer.
- State machine (with skid): EMPTY, MAIN (main register valid), FULL (main and skid valid).
  - EMPTY: input transfer → MAIN.
  - MAIN: input transfer without output transfer → FULL, beat goes to skid. Output transfer without input transfer → EMPTY. Both transfers → MAIN, main reloads from in_data.
  - FULL: output transfer → MAIN, skid moves to main. in_ready=0.
- Without skid: states EMPTY and MAIN only; FULL is unreachable.
- Ordering: strictly FIFO. The skid beat is always older than any later input.
- flush: next state EMPTY regardless of state or handshakes. Any input transfer in the same cycle is discarded. Any output transfer in the same cycle completes normally, because downstream has already sampled it. Payload registers are zeroed on flush so traces and difftest see zeros on bubbles.
- rst: has priority over flush. State EMPTY, out_data=0, skid data=0, occupancy=0, stall_cnt=0.
- stall_cnt: increments by 1 in each cycle with out_valid && !out_ready && !flush. It saturates at 2^CNT_W−1. Cleared only by rst, not by flush.
- out_data always reflects the main register. Its value is don't-care when out_valid=0, but in practice it is 0 after reset or flush.
- Reset values: in_ready=0 during rst, 1 in the first cycle after rst deasserts; out_valid=0; out_data=0; occupancy=0; stall_cnt=0.

## Timing
- Latency: 1 cycle. A beat accepted at edge N is on out_valid/out_data after edge N.
- Throughput: 1 beat/cycle in both configurations while out_ready=1.
- With skid: in_ready = !skid_valid. It is a pure register output with no combinational path from out_ready.
- Without skid: in_ready = !out_valid || out_ready. This is a combinational path from out_ready.
- flush does not affect in_ready in the same cycle. in_ready and flush are sampled independently by upstream.
- occupancy and stall_cnt are registered.

## Configuration
- Macro: YSYX_22040125_STAGE_SKID_EN.
- Defined: the skid register is instantiated, the FULL state exists, in_ready is registered, and occupancy can reach 2.
- Undefined: there is no skid register and occupancy ≤ 1. in_ready depends combinationally on out_ready.
- In both configurations, the port list and the cycle-level behaviour of out_* under uninterrupted out_ready=1 are identical.

## Structure
- Shared package ysyx_22040125_pipe_pkg holds:
  - the state enum (ST_EMPTY, ST_MAIN, ST_FULL);
  - occupancy encoding constants;
  - per-boundary payload width constants (e.g. ID_EXE_W), so that core instances set WIDTH from the package.
- One sub-module: ysyx_22040125_sat_cnt (parametrised CNT_W, sync rst, inc input, saturating), used for stall_cnt.

## Test plan
- Reset/stream: hold rst=1 for 2 cycles, then drive in_valid=1 with data 0x1,0x2,0x3 on consecutive cycles with out_ready=1. Expect out_data 0x1,0x2,0x3 on the next three cycles, out_valid continuous, stall_cnt=0.
- Back-pressure (skid on): MAIN holds 0xA; drive 0xB with out_ready=0. Expect occupancy=2 and in_ready=0 next cycle. Then set out_ready=1 and expect 0xA then 0xB in order.
- Back-pressure (skid off): MAIN holds 0xA, out_ready=0. Expect in_ready=0 combinationally. Raising out_ready=1 with in_valid=1 and 0xB in the same cycle gives out_data=0xB next cycle.
- Flush: occupancy=2, pulse flush with in_valid=1 and 0xC. Expect occupancy=0, out_valid=0, out_data=0 next cycle, and 0xC never appears.
- Stall counter saturation: CNT_W=3, out_valid=1, out_ready=0 for 10 cycles. Expect stall_cnt to reach 7 and hold. A later flush leaves it at 7; rst returns it to 0.
- Reset mid-operation: occupancy=2 and flush=1 with rst=1. Expect all outputs at reset values the next cycle, and in_ready=1 one cycle after rst deasserts.

Source files
------------

// File: rtl/ysyx_22040125_pipe_pkg.sv
// Shared definitions for the ysyx_22040125 pipeline stage registers.
//   - stage_st_e  : occupancy state of one stage register
//   - OCC_*       : occupancy encoding driven on the occupancy port
//   - *_W         : per-boundary payload widths; core instances set WIDTH from these
//   - occ_of()    : state -> occupancy decode
package ysyx_22040125_pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_MAIN  = 2'd1,
    ST_FULL  = 2'd2
  } stage_st_e;

  localparam logic [1:0] OCC_ZERO = 2'd0;
  localparam logic [1:0] OCC_ONE  = 2'd1;
  localparam logic [1:0] OCC_TWO  = 2'd2;

  // Packed field bundle widths at each pipeline boundary.
  localparam int IF_ID_W   = 64 + 32 + 1;            // pc, inst, valid-inst
  localparam int ID_EXE_W  = 64 + 64 + 64 + 64 + 5 + 32; // pc, rs1, rs2, imm, rd, ctrl
  localparam int EXE_MEM_W = 64 + 64 + 64 + 5 + 16;   // pc, alu, store data, rd, ctrl
  localparam int MEM_WB_W  = 64 + 64 + 5 + 8;         // pc, wb data, rd, ctrl

  function automatic logic [1:0] occ_of(input stage_st_e st);
    case (st)
      ST_MAIN: occ_of = OCC_ONE;
      ST_FULL: occ_of = OCC_TWO;
      default: occ_of = OCC_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_22040125_sat_cnt.sv
// Saturating up-counter.
//   i_clk  : clock
//   i_rst  : synchronous active-high reset, clears the count
//   i_inc  : add one this cycle unless already at all-ones
//   o_cnt  : current count
module ysyx_22040125_sat_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst)                    r_cnt <= '0;
    else if (i_inc && ~&r_cnt)    r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/ysyx_22040125_stage_reg.sv
// Generic pipeline stage register with valid/ready handshake, flush and a
// saturating back-pressure counter.
// Optional feature macro: YSYX_22040125_STAGE_SKID_EN adds a skid entry so
// that in_ready is a pure register and throughput stays at one beat/cycle.
// Ports:
//   i_clk, i_rst           : clock, synchronous active-high reset
//   i_flush                : drop all held beats (same-cycle output transfer still completes)
//   i_in_valid/o_in_ready/i_in_data     : upstream handshake + payload
//   o_out_valid/i_out_ready/o_out_data  : downstream handshake + payload (main register)
//   o_occupancy            : beats held (registered)
//   o_stall_cnt            : cycles with out_valid && !out_ready && !flush, saturating
module ysyx_22040125_stage_reg
  import ysyx_22040125_pipe_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out_data,
  output logic [1:0]       o_occupancy,
  output logic [CNT_W-1:0] o_stall_cnt
);

  stage_st_e        r_state, w_state_nxt;
  logic [WIDTH-1:0] r_main,  w_main_nxt;
  logic [1:0]       r_occ;
  // Low only in the cycle(s) right after a reset edge, so in_ready reads 0
  // during reset in both configurations.
  logic             r_rst_done;
  logic             w_in_xfer, w_out_xfer;

`ifdef YSYX_22040125_STAGE_SKID_EN
  logic [WIDTH-1:0] r_skid, w_skid_nxt;
  logic             r_in_ready;
`endif

  assign o_out_valid = (r_state != ST_EMPTY);
  assign w_in_xfer   = i_in_valid && o_in_ready;
  assign w_out_xfer  = o_out_valid && i_out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
`ifdef YSYX_22040125_STAGE_SKID_EN
    w_skid_nxt  = r_skid;
`endif
    case (r_state)
      ST_EMPTY: if (w_in_xfer) begin
        w_main_nxt  = i_in_data;
        w_state_nxt = ST_MAIN;
      end
      ST_MAIN: begin
        if (w_in_xfer && w_out_xfer) w_main_nxt = i_in_data;
        else if (w_out_xfer)         w_state_nxt = ST_EMPTY;
`ifdef YSYX_22040125_STAGE_SKID_EN
        // Downstream stalled: park the new (younger) beat behind main.
        else if (w_in_xfer) begin
          w_skid_nxt  = i_in_data;
          w_state_nxt = ST_FULL;
        end
`endif
      end
`ifdef YSYX_22040125_STAGE_SKID_EN
      ST_FULL: if (w_out_xfer) begin
        w_main_nxt  = r_skid;
        w_skid_nxt  = '0;
        w_state_nxt = ST_MAIN;
      end
`endif
      default: w_state_nxt = ST_EMPTY;
    endcase
    // Zeroed payload keeps bubbles visible as zeros in traces.
    if (i_flush) begin
      w_state_nxt = ST_EMPTY;
      w_main_nxt  = '0;
`ifdef YSYX_22040125_STAGE_SKID_EN
      w_skid_nxt  = '0;
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_EMPTY;
      r_main     <= '0;
      r_occ      <= OCC_ZERO;
      r_rst_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_main     <= w_main_nxt;
      r_occ      <= occ_of(w_state_nxt);
      r_rst_done <= 1'b1;
    end
  end

`ifdef YSYX_22040125_STAGE_SKID_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_skid     <= '0;
      r_in_ready <= 1'b0;
    end else begin
      r_skid     <= w_skid_nxt;
      r_in_ready <= (w_state_nxt != ST_FULL);
    end
  end
  assign o_in_ready = r_in_ready;
`else
  assign o_in_ready = r_rst_done && (!o_out_valid || i_out_ready);
`endif

  assign o_out_data  = r_main;
  assign o_occupancy = r_occ;

  ysyx_22040125_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_inc (o_out_valid && !i_out_ready && !i_flush),
    .o_cnt (o_stall_cnt)
  );

endmodule
